// File: rtl/uart_protocol_tx.sv
// Image/label frame transmitter: START, mode, pixel bytes, label, checksum, STOP,
// with a single whole-frame retransmit when the far end requests it after the checksum.
module uart_protocol_tx #(
    parameter int unsigned IMG_SZ      = 784 << 3,
    parameter int unsigned RESEND_WAIT = 16
) (
    input  logic              uart_sampling_clk,
    input  logic              rst,
    input  logic              send,
    input  logic              train,
    input  logic [7:0]        label,
    input  logic [IMG_SZ-1:0] image,
    input  logic              resend,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_byte,
    output logic              busy,
    output logic              done
);

    localparam int unsigned NB = IMG_SZ / 8;
    localparam int unsigned WW = (RESEND_WAIT > 1) ? $clog2(RESEND_WAIT) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_MODE  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_LABEL = 3'd4;
    localparam logic [2:0] S_CHECK = 3'd5;
    localparam logic [2:0] S_WAIT  = 3'd6;
    localparam logic [2:0] S_STOP  = 3'd7;

    logic [2:0]        state, state_n;
    logic [15:0]       cnt, cnt_n;
    logic [WW-1:0]     wcnt, wcnt_n;
    logic [7:0]        cs, cs_n;
    logic              resent, resent_n;
    logic [IMG_SZ-1:0] img_q, img_n;
    logic [7:0]        label_q, label_n;
    logic [7:0]        mode_q, mode_n;
    logic              tx_valid_n;
    logic [7:0]        tx_byte_n;
    logic              busy_n;
    logic              done_n;
    logic              xfer;
    logic [IMG_SZ-1:0] img_sh;

    // One's-complement add with end-around carry; the result never re-overflows.
    function automatic logic [7:0] oc_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[7:0] + {7'd0, s[8]};
    endfunction

    always_ff @(posedge uart_sampling_clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            wcnt     <= '0;
            cs       <= '0;
            resent   <= 1'b0;
            img_q    <= '0;
            label_q  <= '0;
            mode_q   <= '0;
            tx_valid <= 1'b0;
            tx_byte  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            wcnt     <= wcnt_n;
            cs       <= cs_n;
            resent   <= resent_n;
            img_q    <= img_n;
            label_q  <= label_n;
            mode_q   <= mode_n;
            tx_valid <= tx_valid_n;
            tx_byte  <= tx_byte_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    // Next state plus the byte that the next state will present, so outputs stay registered.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        wcnt_n     = wcnt;
        cs_n       = cs;
        resent_n   = resent;
        img_n      = img_q;
        label_n    = label_q;
        mode_n     = mode_q;
        done_n     = 1'b0;
        tx_valid_n = 1'b0;
        tx_byte_n  = 8'h00;
        img_sh     = '0;
        xfer       = tx_valid && tx_ready;

        case (state)
            S_IDLE: begin
                if (send) begin
                    state_n = S_START;
                    img_n   = image;
                    label_n = label;
                    mode_n  = train ? 8'hf0 : 8'h0f;
                    cs_n    = 8'h00;
                    cnt_n   = 16'd0;
                end
            end
            S_START: if (xfer) state_n = S_MODE;
            S_MODE:  if (xfer) state_n = S_DATA;
            S_DATA: begin
                if (xfer) begin
                    cs_n = oc_add(cs, tx_byte);
                    if (cnt == 16'(NB - 1)) begin
                        cnt_n   = 16'd0;
                        state_n = S_LABEL;
                    end else begin
                        cnt_n = cnt + 16'd1;
                    end
                end
            end
            S_LABEL: begin
                if (xfer) begin
                    cs_n    = oc_add(cs, tx_byte);
                    state_n = S_CHECK;
                end
            end
            S_CHECK: begin
                if (xfer) begin
                    state_n = S_WAIT;
                    wcnt_n  = '0;
                end
            end
            S_WAIT: begin
                if (resend && !resent) begin
                    resent_n = 1'b1;
                    cs_n     = 8'h00;
                    cnt_n    = 16'd0;
                    state_n  = S_START;
                end else if (wcnt == WW'(RESEND_WAIT - 1)) begin
                    state_n = S_STOP;
                end else begin
                    wcnt_n = wcnt + WW'(1);
                end
            end
            S_STOP: begin
                if (xfer) begin
                    state_n  = S_IDLE;
                    done_n   = 1'b1;
                    resent_n = 1'b0;
                end
            end
            default: state_n = S_IDLE;
        endcase

        img_sh = img_n << {cnt_n, 3'b000};
        case (state_n)
            S_START: begin tx_valid_n = 1'b1; tx_byte_n = 8'hff; end
            S_MODE:  begin tx_valid_n = 1'b1; tx_byte_n = mode_n; end
            S_DATA:  begin tx_valid_n = 1'b1; tx_byte_n = img_sh[IMG_SZ-1 -: 8]; end
            S_LABEL: begin tx_valid_n = 1'b1; tx_byte_n = label_n; end
            S_CHECK: begin tx_valid_n = 1'b1; tx_byte_n = cs_n; end
            S_STOP:  begin tx_valid_n = 1'b1; tx_byte_n = 8'hbb; end
            default: begin tx_valid_n = 1'b0; tx_byte_n = 8'h00; end
        endcase

        busy_n = (state_n != S_IDLE);
    end

endmodule

// File: tb/tb_uart_protocol_tx.sv
// Scoreboard bench for uart_protocol_tx with a 4-byte image and a 4-cycle resend window.
module tb_uart_protocol_tx;

    localparam int unsigned IMG = 32;
    localparam int unsigned RW  = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           send;
    logic           train;
    logic [7:0]     label;
    logic [IMG-1:0] image;
    logic           resend;
    logic           tx_ready;
    logic           tx_valid;
    logic [7:0]     tx_byte;
    logic           busy;
    logic           done;

    uart_protocol_tx #(.IMG_SZ(IMG), .RESEND_WAIT(RW)) dut (
        .uart_sampling_clk(clk),
        .rst(rst),
        .send(send),
        .train(train),
        .label(label),
        .image(image),
        .resend(resend),
        .tx_ready(tx_ready),
        .tx_valid(tx_valid),
        .tx_byte(tx_byte),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        int         gap;   // idle busy cycles expected before this byte; -1 = don't care
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   gap_cnt = 0;
    bit   bp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [7:0] b, input int gap);
        exp_t e;
        e.b = b;
        e.gap = gap;
        q.push_back(e);
    endtask

    // Expected frame bytes; checksum is hand-computed by the caller.
    task automatic push_frame(input logic [7:0] mode, input logic [31:0] img,
                              input logic [7:0] lbl, input logic [7:0] cs,
                              input int ff_gap, input bit with_stop);
        logic [31:0] v;
        v = img;
        push(8'hff, ff_gap);
        push(mode, 0);
        for (int k = 0; k < 4; k++) push(v[31-8*k -: 8], 0);
        push(lbl, 0);
        push(cs, 0);
        if (with_stop) push(8'hbb, RW);
    endtask

    task automatic do_send(input bit tr, input logic [31:0] img, input logic [7:0] lbl);
        @(posedge clk); #1;
        send = 1'b1; train = tr; image = img; label = lbl;
        @(posedge clk); #1;
        send = 1'b0;
        chk("busy_after_send", busy, 1);
    endtask

    task automatic wait_done(input int start, input int budget);
        for (int i = 0; i < budget && done_cnt == start; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        chk("done_once", done_cnt, start + 1);
        chk("queue_drained", q.size(), 0);
        chk("idle_busy", busy, 0);
    endtask

    task automatic wait_byte(input logic [7:0] b);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (tx_valid && tx_ready && tx_byte == b) seen = 1'b1;
        end
        chk("wait_byte_seen", 32'(seen), 1);
        @(posedge clk);
    endtask

    // Monitor: pops one expected byte per transfer, checks gaps, stalls and done width.
    initial begin
        exp_t e;
        bit   stalled;
        bit   done_prev;
        logic [7:0] held;
        stalled = 1'b0; done_prev = 1'b0; held = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0; done_prev = 1'b0; gap_cnt = 0;
            end else begin
                if (stalled) begin
                    chk("stall_valid", 32'(tx_valid), 1);
                    chk("stall_byte", 32'(tx_byte), 32'(held));
                end
                if (done) begin
                    done_cnt++;
                    chk("done_width", 32'(done_prev), 0);
                end
                done_prev = done;
                if (tx_valid && tx_ready) begin
                    if (q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_byte: got %0h want none at %0t", tx_byte, $time);
                    end else begin
                        e = q.pop_front();
                        chk("byte", 32'(tx_byte), 32'(e.b));
                        if (e.gap >= 0) chk("gap", gap_cnt, e.gap);
                    end
                    gap_cnt = 0;
                end else if (!tx_valid && busy) begin
                    gap_cnt++;
                end
                stalled = tx_valid && !tx_ready;
                held = tx_byte;
            end
        end
    end

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            tx_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int start;
        rst = 1'b1; send = 1'b0; train = 1'b0; label = 8'h00; image = '0; resend = 1'b0;
        #12;
        chk("rst_valid", 32'(tx_valid), 0);
        chk("rst_byte", 32'(tx_byte), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1. basic frame
        start = done_cnt;
        push_frame(8'hf0, 32'h01020304, 8'h07, 8'h11, 0, 1'b1);
        do_send(1'b1, 32'h01020304, 8'h07);
        wait_done(start, 200);

        // 2. end-around carry
        start = done_cnt;
        push_frame(8'h0f, 32'hff010000, 8'h00, 8'h01, 0, 1'b1);
        do_send(1'b0, 32'hff010000, 8'h00);
        wait_done(start, 200);

        // 3. random backpressure
        bp_en = 1'b1;
        start = done_cnt;
        push_frame(8'hf0, 32'h01020304, 8'h07, 8'h11, 0, 1'b1);
        do_send(1'b1, 32'h01020304, 8'h07);
        wait_done(start, 1000);
        bp_en = 1'b0;
        repeat (2) @(posedge clk);

        // 4. resend honoured once, second request ignored
        start = done_cnt;
        push_frame(8'hf0, 32'h01020304, 8'h07, 8'h11, 0, 1'b0);
        push_frame(8'hf0, 32'h01020304, 8'h07, 8'h11, 3, 1'b1);
        do_send(1'b1, 32'h01020304, 8'h07);
        wait_byte(8'h11);
        repeat (2) @(posedge clk);
        #1 resend = 1'b1;
        @(posedge clk); #1 resend = 1'b0;
        wait_byte(8'h11);
        #1 resend = 1'b1;
        repeat (6) @(posedge clk);
        #1 resend = 1'b0;
        wait_done(start, 200);

        // 5. send while busy is ignored
        start = done_cnt;
        push_frame(8'hf0, 32'h01020304, 8'h07, 8'h11, 0, 1'b1);
        do_send(1'b1, 32'h01020304, 8'h07);
        repeat (2) @(posedge clk);
        #1 send = 1'b1; train = 1'b0; image = 32'haabbccdd; label = 8'h55;
        @(posedge clk); #1 send = 1'b0;
        wait_done(start, 200);

        // 6. asynchronous reset mid-data, then a clean frame
        start = done_cnt;
        push(8'hff, 0); push(8'hf0, 0); push(8'h01, 0);
        do_send(1'b1, 32'h01020304, 8'h07);
        wait_byte(8'h01);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(tx_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_queue", q.size(), 0);
        q.delete();
        @(posedge clk); #1 rst = 1'b0;
        chk("arst_no_done", done_cnt, start);
        start = done_cnt;
        push_frame(8'h0f, 32'hff010000, 8'h00, 8'h01, 0, 1'b1);
        do_send(1'b0, 32'hff010000, 8'h00);
        wait_done(start, 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
